// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the period decoder slice: controller state encoding,
// symbol codes and symbol FIFO geometry.
// -----------------------------------------------------------------------------
package decoder_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_CLASSIFY = 2'd2,
        ST_PUSH     = 2'd3
    } state_e;

    // Symbol codes
    localparam logic [1:0] SYM_0   = 2'd0;
    localparam logic [1:0] SYM_1   = 2'd1;
    localparam logic [1:0] SYM_2   = 2'd2;
    localparam logic [1:0] SYM_INV = 2'd3;

    // Symbol FIFO geometry; the level needs one bit more than the pointers
    // so that "full" (4) is distinguishable from "empty" (0).
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_LVL_W = 3;

endpackage

// File: rtl/sym_fifo.sv
// -----------------------------------------------------------------------------
// sym_fifo
// Four-entry first-word-fall-through FIFO holding {symbol, average} words.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise the word is dropped (the parent flags the drop).
//
// Ports:
//   clk, reset_l   clock, asynchronous active-low reset
//   clr            synchronous clear of pointers and level (wins over push/pop)
//   push, wdata    write request and data
//   pop            read request (ignored while empty)
//   rdata          head word, valid while !empty
//   level          number of entries held (0..4)
//   full, empty    status flags
// -----------------------------------------------------------------------------
module sym_fifo
    import decoder_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic [FIFO_LVL_W-1:0] level,
    output logic                  full,
    output logic                  empty
);

    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LVL_W-1:0] level_q, level_d;
    logic                  pop_ok;
    logic                  push_ok;

    assign empty = (level_q == '0);
    assign full  = (level_q == FIFO_LVL_W'(FIFO_DEPTH));

    // At full, a same-cycle pop frees the head slot, which is exactly the
    // slot the write pointer addresses, so the push can be taken.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + FIFO_PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + FIFO_LVL_W'(1);
                2'b01:   level_d = level_q - FIFO_LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; the parent masks the head while empty.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/period_decoder.sv
// -----------------------------------------------------------------------------
// period_decoder
// Averages groups of 2^AVG_LOG2 measured periods, classifies each average into
// a 2-bit symbol and queues {symbol, average} in a 4-entry FWFT FIFO.
// A period is captured once per rising edge of period_valid. AVG_LOG2 >= 1.
//
// Ports:
//   clk, reset_l   clock, asynchronous active-low reset
//   period_valid   level, high while the upstream period count is final
//   period         measured period in samples
//   flush          synchronous clear of accumulator, FIFO and overflow flag
//   sym_ready      downstream accepts the head symbol
//   sym_valid      FIFO head valid
//   sym, sym_avg   head symbol code and its averaged period (0 while empty)
//   fifo_level     entries held (0..4)
//   overflow       sticky: a symbol was dropped at a full FIFO
// -----------------------------------------------------------------------------
module period_decoder
    import decoder_pkg::*;
#(
    parameter int W_N_MAX  = 8,
    parameter int AVG_LOG2 = 2,
    parameter int TH_LO    = 20,
    parameter int TH_HI    = 40
) (
    input  logic               clk,
    input  logic               reset_l,
    input  logic               period_valid,
    input  logic [W_N_MAX-1:0] period,
    input  logic               flush,
    input  logic               sym_ready,
    output logic               sym_valid,
    output logic [1:0]         sym,
    output logic [W_N_MAX-1:0] sym_avg,
    output logic [2:0]         fifo_level,
    output logic               overflow
);

    localparam int ACC_W  = W_N_MAX + AVG_LOG2;
    localparam int CNT_W  = AVG_LOG2;
    localparam int FIFO_W = 2 + W_N_MAX;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    // avg == 0 means no usable measurement; thresholds: [1,TH_LO) -> 0,
    // [TH_LO,TH_HI] -> 1, above TH_HI -> 2.
    function automatic logic [1:0] classify(input logic [W_N_MAX-1:0] avg_in);
        logic [31:0] avg_ext;
        avg_ext = 32'(avg_in);
        if (avg_in == '0) begin
            return SYM_INV;
        end else if (avg_ext < 32'(TH_LO)) begin
            return SYM_0;
        end else if (avg_ext <= 32'(TH_HI)) begin
            return SYM_1;
        end else begin
            return SYM_2;
        end
    endfunction

    logic               pv_q, pv_d;
    logic               capture;
    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cls_sym_q, cls_sym_d;
    logic [W_N_MAX-1:0] cls_avg_q, cls_avg_d;
    logic [W_N_MAX-1:0] avg;
    logic               overflow_q, overflow_d;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FIFO_W-1:0]  fifo_rdata;
    logic [2:0]         level;

    // One capture per rising edge, however long period_valid stays high.
    assign capture = period_valid & ~pv_q;

    // Truncating average: sum of 2^AVG_LOG2 periods always fits W_N_MAX bits
    // once shifted back down.
    assign avg = W_N_MAX'(acc_q >> AVG_LOG2);

    assign sym_valid = ~fifo_empty;
    assign pop       = sym_valid & sym_ready;

    always_comb begin
        pv_d      = period_valid;
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        cls_sym_d = cls_sym_q;
        cls_avg_d = cls_avg_q;
        push      = 1'b0;

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (capture) begin
                    acc_d = acc_q + ACC_W'(period);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_CLASSIFY;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_CLASSIFY: begin
                cls_avg_d = avg;
                cls_sym_d = classify(avg);
                state_d   = ST_PUSH;
                // The finished sum is consumed here, so a new edge now
                // starts the next group instead of being lost.
                if (capture) begin
                    acc_d = ACC_W'(period);
                    cnt_d = CNT_W'(1);
                end else begin
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            ST_PUSH: begin
                push = 1'b1;
                if (capture) begin
                    acc_d = acc_q + ACC_W'(period);
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = (capture || cnt_q != '0) ? ST_ACCUM : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush overrides any capture, classification or push in flight.
        if (flush) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            push    = 1'b0;
        end

        if (flush) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q | (push & fifo_full & ~pop);
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            pv_q       <= 1'b0;
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            pv_q       <= pv_d;
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Classification result only matters while in ST_PUSH; no reset needed.
    always_ff @(posedge clk) begin
        cls_sym_q <= cls_sym_d;
        cls_avg_q <= cls_avg_d;
    end

    sym_fifo #(
        .WIDTH (FIFO_W)
    ) u_sym_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .clr     (flush),
        .push    (push),
        .pop     (pop),
        .wdata   ({cls_sym_q, cls_avg_q}),
        .rdata   (fifo_rdata),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head is masked while empty so outputs read zero after reset/flush.
    assign sym        = sym_valid ? fifo_rdata[FIFO_W-1 -: 2] : 2'b00;
    assign sym_avg    = sym_valid ? fifo_rdata[W_N_MAX-1:0] : '0;
    assign fifo_level = level;
    assign overflow   = overflow_q;

endmodule
